// File: rtl/login_ctrl_if.sv
// Request/response and user-record SRAM bus of the access-control sequencer.
// The slave modport belongs to login_ctrl; the master modport is the side that
// issues requests and hosts the SRAM.
interface login_ctrl_if;
    // request side
    logic        start;
    logic [1:0]  op;
    logic [11:0] user_id;
    logic [15:0] pass_entry;
    logic [15:0] new_pass;
    logic [11:0] target_id;
    // response side
    logic        busy;
    logic        done;
    logic [1:0]  res;
    logic [3:0]  tries;
    logic        is_admin;
    // SRAM controls and write data
    logic        ram_cs;
    logic        ram_pass_rw;
    logic        ram_admin_rw;
    logic        ram_lock_rw;
    logic        ram_count_rw;
    logic [11:0] ram_addr;
    logic [15:0] ram_pass_in;
    logic [3:0]  ram_count_in;
    logic        ram_admin_in;
    logic        ram_lock_in;
    // SRAM read data
    logic [15:0] ram_pass_out;
    logic [3:0]  ram_count_out;
    logic        ram_admin_out;
    logic        ram_lock_out;

    modport master (
        output start, op, user_id, pass_entry, new_pass, target_id,
        input  busy, done, res, tries, is_admin,
        input  ram_cs, ram_pass_rw, ram_admin_rw, ram_lock_rw, ram_count_rw,
        input  ram_addr, ram_pass_in, ram_count_in, ram_admin_in, ram_lock_in,
        output ram_pass_out, ram_count_out, ram_admin_out, ram_lock_out
    );

    modport slave (
        input  start, op, user_id, pass_entry, new_pass, target_id,
        output busy, done, res, tries, is_admin,
        output ram_cs, ram_pass_rw, ram_admin_rw, ram_lock_rw, ram_count_rw,
        output ram_addr, ram_pass_in, ram_count_in, ram_admin_in, ram_lock_in,
        input  ram_pass_out, ram_count_out, ram_admin_out, ram_lock_out
    );
endinterface

// File: rtl/login_ctrl.sv
// Access-control sequencer: one request at a time, read -> evaluate ->
// write-back -> respond, with try counting and lockout on the user record.
module login_ctrl #(
    parameter int MAX_TRY = 3
) (
    input  logic         clk,
    input  logic         rst,
    login_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, RESP} state_t;

    localparam logic [1:0] RES_GRANT  = 2'b00;
    localparam logic [1:0] RES_DENIED = 2'b01;
    localparam logic [1:0] RES_LOCKED = 2'b10;
    localparam logic [1:0] RES_NOPRIV = 2'b11;
    localparam logic [1:0] OP_CHPASS  = 2'b01;
    localparam logic [1:0] OP_UNLOCK  = 2'b10;
    localparam logic [3:0] MAX_TRY_C  = 4'(MAX_TRY);

    // Try counter increment that sticks at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

    state_t      state, state_nxt;

    // latched request
    logic [1:0]  op_q;
    logic [11:0] uid_q, tgt_q;
    logic [15:0] pent_q, newp_q;

    // decision computed while the record sits on the SRAM outputs
    logic        ev_wr, ev_pass_rw, ev_lock_rw, ev_count_rw, ev_lock_in;
    logic [11:0] ev_addr;
    logic [15:0] ev_pass_in;
    logic [3:0]  ev_count_in, ev_tries, cnt_inc;
    logic [1:0]  ev_res;

    // registered SRAM drive and response
    logic        ram_cs_q, pass_rw_q, lock_rw_q, count_rw_q, lock_in_q;
    logic [11:0] addr_q;
    logic [15:0] pass_in_q;
    logic [3:0]  count_in_q;
    logic [1:0]  res_p, res_q;
    logic [3:0]  tries_p, tries_q;
    logic        adm_p, adm_q;

    // State register; reset returns to IDLE at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: fixed five-step walk, start only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = READ;
            READ:    state_nxt = EVAL;
            EVAL:    state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture; plain data, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            op_q   <= bus.op;
            uid_q  <= bus.user_id;
            tgt_q  <= bus.target_id;
            pent_q <= bus.pass_entry;
            newp_q <= bus.new_pass;
        end
    end

    // Evaluate the record read from the SRAM against the latched request.
    always_comb begin
        cnt_inc     = sat_inc(bus.ram_count_out);
        ev_wr       = 1'b0;
        ev_pass_rw  = 1'b0;
        ev_lock_rw  = 1'b0;
        ev_count_rw = 1'b0;
        ev_lock_in  = 1'b0;
        ev_addr     = uid_q;
        ev_pass_in  = 16'h0000;
        ev_count_in = 4'h0;
        ev_tries    = bus.ram_count_out;
        ev_res      = RES_GRANT;
        if (bus.ram_lock_out) begin
            ev_res = RES_LOCKED;
        end else if (bus.ram_pass_out != pent_q) begin
            // wrong password counts against the requester whatever the op
            ev_wr       = 1'b1;
            ev_count_rw = 1'b1;
            ev_count_in = cnt_inc;
            ev_tries    = cnt_inc;
            if (cnt_inc >= MAX_TRY_C) begin
                ev_res     = RES_LOCKED;
                ev_lock_rw = 1'b1;
                ev_lock_in = 1'b1;
            end else begin
                ev_res = RES_DENIED;
            end
        end else if (op_q == OP_UNLOCK) begin
            // the requester's own record is left alone; only the target is written
            if (bus.ram_admin_out) begin
                ev_wr       = 1'b1;
                ev_addr     = tgt_q;
                ev_lock_rw  = 1'b1;
                ev_count_rw = 1'b1;
            end else begin
                ev_res = RES_NOPRIV;
            end
        end else begin
            ev_wr       = 1'b1;
            ev_count_rw = 1'b1;
            ev_tries    = 4'h0;
            if (op_q == OP_CHPASS) begin
                ev_pass_rw = 1'b1;
                ev_pass_in = newp_q;
            end
        end
    end

    // SRAM drive and response registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_cs_q   <= 1'b0;
            pass_rw_q  <= 1'b0;
            lock_rw_q  <= 1'b0;
            count_rw_q <= 1'b0;
            lock_in_q  <= 1'b0;
            addr_q     <= 12'h000;
            pass_in_q  <= 16'h0000;
            count_in_q <= 4'h0;
            res_p      <= 2'b00;
            tries_p    <= 4'h0;
            adm_p      <= 1'b0;
            res_q      <= 2'b00;
            tries_q    <= 4'h0;
            adm_q      <= 1'b0;
        end else begin
            ram_cs_q   <= 1'b0;
            pass_rw_q  <= 1'b0;
            lock_rw_q  <= 1'b0;
            count_rw_q <= 1'b0;
            lock_in_q  <= 1'b0;
            addr_q     <= 12'h000;
            pass_in_q  <= 16'h0000;
            count_in_q <= 4'h0;
            case (state)
                IDLE: if (bus.start) begin
                    ram_cs_q <= 1'b1;
                    addr_q   <= bus.user_id;
                end
                EVAL: begin
                    ram_cs_q   <= ev_wr;
                    pass_rw_q  <= ev_pass_rw;
                    lock_rw_q  <= ev_lock_rw;
                    count_rw_q <= ev_count_rw;
                    lock_in_q  <= ev_lock_in;
                    addr_q     <= ev_addr;
                    pass_in_q  <= ev_pass_in;
                    count_in_q <= ev_count_in;
                    res_p      <= ev_res;
                    tries_p    <= ev_tries;
                    adm_p      <= bus.ram_admin_out;
                end
                WRITE: begin
                    res_q   <= res_p;
                    tries_q <= tries_p;
                    adm_q   <= adm_p;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == RESP);
    assign bus.res          = res_q;
    assign bus.tries        = tries_q;
    assign bus.is_admin     = adm_q;
    assign bus.ram_cs       = ram_cs_q;
    assign bus.ram_pass_rw  = pass_rw_q;
    assign bus.ram_admin_rw = 1'b0;
    assign bus.ram_lock_rw  = lock_rw_q;
    assign bus.ram_count_rw = count_rw_q;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_pass_in  = pass_in_q;
    assign bus.ram_count_in = count_in_q;
    assign bus.ram_admin_in = 1'b0;
    assign bus.ram_lock_in  = lock_in_q;
endmodule

// File: tb/tb_login_ctrl.sv
// Directed bench for login_ctrl with a behavioural user-record SRAM.
`timescale 1ns/1ps
module tb_login_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    login_ctrl_if bus ();

    login_ctrl #(.MAX_TRY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural SRAM: synchronous, one-cycle read latency, per-field write enables.
    logic [15:0] m_pass  [4096];
    logic [3:0]  m_count [4096];
    logic        m_admin [4096];
    logic        m_lock  [4096];
    int          wr_n = 0;
    int          adm_wr_n = 0;
    logic [11:0] wr_addr;
    logic        wr_pass_rw, wr_lock_rw, wr_count_rw, wr_lock_in;
    logic [15:0] wr_pass_in;
    logic [3:0]  wr_count_in;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            m_pass[i] = 16'h0000; m_count[i] = 4'h0; m_admin[i] = 1'b0; m_lock[i] = 1'b0;
        end
        m_pass[12'h005] = 16'hBEEF;
        m_pass[12'h001] = 16'hA001; m_admin[12'h001] = 1'b1;
        m_pass[12'h002] = 16'hA002;
        m_pass[12'h009] = 16'h0909; m_count[12'h009] = 4'hF;
        bus.ram_pass_out  <= 16'h0000;
        bus.ram_count_out <= 4'h0;
        bus.ram_admin_out <= 1'b0;
        bus.ram_lock_out  <= 1'b0;
        forever begin
            @(posedge clk);
            if (bus.ram_cs) begin
                if (bus.ram_pass_rw || bus.ram_lock_rw || bus.ram_count_rw || bus.ram_admin_rw) begin
                    wr_n++;
                    wr_addr     = bus.ram_addr;
                    wr_pass_rw  = bus.ram_pass_rw;
                    wr_lock_rw  = bus.ram_lock_rw;
                    wr_count_rw = bus.ram_count_rw;
                    wr_lock_in  = bus.ram_lock_in;
                    wr_pass_in  = bus.ram_pass_in;
                    wr_count_in = bus.ram_count_in;
                end
                if (bus.ram_admin_rw) adm_wr_n++;
                if (bus.ram_pass_rw)  m_pass[bus.ram_addr]  = bus.ram_pass_in;
                else                  bus.ram_pass_out     <= m_pass[bus.ram_addr];
                if (bus.ram_count_rw) m_count[bus.ram_addr] = bus.ram_count_in;
                else                  bus.ram_count_out    <= m_count[bus.ram_addr];
                if (bus.ram_lock_rw)  m_lock[bus.ram_addr]  = bus.ram_lock_in;
                else                  bus.ram_lock_out     <= m_lock[bus.ram_addr];
                if (bus.ram_admin_rw) m_admin[bus.ram_addr] = bus.ram_admin_in;
                else                  bus.ram_admin_out    <= m_admin[bus.ram_addr];
            end
        end
    end

    int          lat;
    int          wr_before;
    logic [1:0]  r_res;
    logic [3:0]  r_tries;
    logic        r_adm;

    // Issue one request, measure edges from acceptance to done, capture the response.
    task automatic req(input logic [1:0] op, input logic [11:0] uid, input logic [15:0] pe,
                       input logic [15:0] np, input logic [11:0] tgt);
        @(negedge clk);
        wr_before      = wr_n;
        bus.start      = 1'b1;
        bus.op         = op;
        bus.user_id    = uid;
        bus.pass_entry = pe;
        bus.new_pass   = np;
        bus.target_id  = tgt;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 99;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        r_res   = bus.res;
        r_tries = bus.tries;
        r_adm   = bus.is_admin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b1; bus.op = 2'b00; bus.user_id = 12'h000;
        bus.pass_entry = 16'h0000; bus.new_pass = 16'h0000; bus.target_id = 12'h000;

        // reset held with start asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_res",   bus.res, 0);
        chk("rst_tries", bus.tries, 0);
        chk("rst_cs",    bus.ram_cs, 0);
        chk("rst_addr",  bus.ram_addr, 0);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 chk("idle_after_rst", bus.busy, 0);

        // good login
        req(2'b00, 12'h005, 16'hBEEF, 16'h0, 12'h0);
        chk("login_lat",   lat, 3);
        chk("login_res",   r_res, 2'b00);
        chk("login_tries", r_tries, 0);
        chk("login_wr_n",  wr_n - wr_before, 1);
        chk("login_wr_a",  wr_addr, 12'h005);
        chk("login_wr_rw", {wr_pass_rw, wr_lock_rw, wr_count_rw}, 3'b001);
        chk("login_wr_c",  wr_count_in, 0);

        // three wrong logins
        req(2'b00, 12'h005, 16'h0000, 16'h0, 12'h0);
        chk("bad1_res", r_res, 2'b01); chk("bad1_tries", r_tries, 1);
        req(2'b00, 12'h005, 16'h0000, 16'h0, 12'h0);
        chk("bad2_res", r_res, 2'b01); chk("bad2_tries", r_tries, 2);
        chk("bad2_lockrw", wr_lock_rw, 0);
        req(2'b00, 12'h005, 16'h0000, 16'h0, 12'h0);
        chk("bad3_res", r_res, 2'b10); chk("bad3_tries", r_tries, 3);
        chk("bad3_wr", {wr_lock_rw, wr_lock_in, wr_count_rw}, 3'b111);
        chk("bad3_mlock", m_lock[12'h005], 1);

        // correct password on a locked user
        req(2'b00, 12'h005, 16'hBEEF, 16'h0, 12'h0);
        chk("lockd_res", r_res, 2'b10); chk("lockd_tries", r_tries, 3);
        chk("lockd_wr_n", wr_n - wr_before, 0);

        // admin unlock
        req(2'b10, 12'h001, 16'hA001, 16'h0, 12'h005);
        chk("unl_res", r_res, 2'b00); chk("unl_adm", r_adm, 1); chk("unl_tries", r_tries, 0);
        chk("unl_wr_n", wr_n - wr_before, 1);
        chk("unl_wr_a", wr_addr, 12'h005);
        chk("unl_mem", {m_lock[12'h005], m_count[12'h005]}, 5'h00);

        // non-admin unlock attempt
        req(2'b10, 12'h002, 16'hA002, 16'h0, 12'h005);
        chk("nopriv_res", r_res, 2'b11); chk("nopriv_adm", r_adm, 0);
        chk("nopriv_wr_n", wr_n - wr_before, 0);

        // password change then logins with new and old password
        req(2'b01, 12'h005, 16'hBEEF, 16'h1234, 12'h0);
        chk("chp_res", r_res, 2'b00);
        chk("chp_wr_rw", {wr_pass_rw, wr_lock_rw, wr_count_rw}, 3'b101);
        chk("chp_mem", m_pass[12'h005], 16'h1234);
        req(2'b00, 12'h005, 16'h1234, 16'h0, 12'h0);
        chk("newpw_res", r_res, 2'b00);
        req(2'b00, 12'h005, 16'hBEEF, 16'h0, 12'h0);
        chk("oldpw_res", r_res, 2'b01); chk("oldpw_tries", r_tries, 1);

        // reserved op behaves as login
        req(2'b11, 12'h005, 16'h1234, 16'h0, 12'h0);
        chk("op11_res", r_res, 2'b00); chk("op11_tries", r_tries, 0);

        // saturated count on a wrong login
        req(2'b00, 12'h009, 16'h0000, 16'h0, 12'h0);
        chk("sat_res", r_res, 2'b10); chk("sat_tries", r_tries, 15);
        chk("sat_mem", {m_lock[12'h009], m_count[12'h009]}, 5'h1F);

        // start pulsed during READ and during RESP is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.user_id = 12'h005; bus.pass_entry = 16'h1234;
        @(posedge clk);
        #1 chk("ign_busy0", bus.busy, 1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("ign_done", bus.done, 1);
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("ign_resp", bus.busy, 0);
        @(posedge clk);
        #1 chk("ign_idle", bus.busy, 0);

        // asynchronous reset during the write cycle
        @(negedge clk);
        bus.start = 1'b1; bus.user_id = 12'h005; bus.pass_entry = 16'h1234;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("arst_wcs", bus.ram_cs, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_cs",   bus.ram_cs, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_res",  bus.res, 0);
        chk("arst_rw",   bus.ram_count_rw, 0);
        @(negedge clk) rst = 1'b1;

        chk("admin_rw_never", adm_wr_n, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
